// File: rtl/key_pkg.sv
// Shared constants for the key input path: FSM state encoding and default
// 50 MHz timing thresholds used by key_filter consumers.
package key_pkg;

  // 2-bit state encoding for the click decoder FSM
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD1    = 2'd1;
  localparam logic [1:0] ST_GAP      = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StHold1   = ST_HOLD1,
    StGap     = ST_GAP,
    StWaitRel = ST_WAIT_REL
  } key_state_e;

  // 1 s long press and 250 ms double-click window at 50 MHz
  localparam int unsigned KEY_LONG_CYC = 50_000_000;
  localparam int unsigned KEY_GAP_CYC  = 12_500_000;

endpackage

// File: rtl/key_click_decoder.sv
// Classifies debounced press/release pulses into single-click, double-click
// and long-press events. One FSM plus one shared up-counter; all outputs are
// registered, so every event appears one cycle after its deciding condition.
module key_click_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC = KEY_LONG_CYC,
  parameter int unsigned GAP_CYC  = KEY_GAP_CYC
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_p_flag,
  input  logic key_r_flag,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic busy
);

  localparam int unsigned MaxCyc = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  key_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            press;
  logic            release_ev;

  // A press and release in the same cycle cancel out and are both ignored
  always_comb begin
    press      = key_p_flag & ~key_r_flag;
    release_ev = key_r_flag & ~key_p_flag;
  end

  // FSM, shared counter and registered event outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (press) begin
            state_q <= StHold1;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StHold1: begin
          // Release takes priority over a coincident long-press timeout
          if (release_ev) begin
            state_q <= StGap;
            cnt_q   <= '0;
          end else if (cnt_q == LongLast) begin
            long_pulse <= 1'b1;
            state_q    <= StWaitRel;
            cnt_q      <= '0;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          // Second press takes priority over a coincident single-click timeout
          if (press) begin
            double_pulse <= 1'b1;
            state_q      <= StWaitRel;
            cnt_q        <= '0;
          end else if (cnt_q == GapLast) begin
            single_pulse <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= '0;
            busy         <= 1'b0;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitRel: begin
          if (release_ev) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
